// File: rtl/mult_bist_ctrl.sv
// ---------------------------------------------------------------------------
// mult_bist_ctrl
//
// Built-in self-test controller for the 4-bit array multiplier.
//
// An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) generates operand pairs for
// the multiplier. An 8-bit MISR using the same polynomial compacts every
// returned product into a signature. When a run finishes, the signature is
// compared against golden_sig and the result is held on pass while done is
// high.
//
// Phases: IDLE -> SEED -> RUN -> [FLUSH] -> CMP -> DONE
//
// Optional feature (compile-time macro): MULT_BIST_PIPE_EN
//   defined   : the product is registered (p_q, v_q) before compaction, and
//               one FLUSH cycle drains the last registered product. done
//               therefore rises one cycle later. The final signature is the
//               same as in the default build.
//   undefined : mul_p is compacted combinationally during RUN; FLUSH is
//               never entered.
//
// Parameters
//   PATTERNS   patterns per run, legal range 1..255
//   LFSR_SEED  LFSR load value, must be non-zero
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   begin a run (accepted only in IDLE or DONE)
//   golden_sig in   [7:0] expected signature, sampled in CMP
//   mul_p      in   [7:0] multiplier product
//   mul_a      out  [3:0] operand A = lfsr[7:4]
//   mul_b      out  [3:0] operand B = lfsr[3:0]
//   test_mode  out  high in RUN and FLUSH (wrapper selects mul_a/mul_b)
//   busy       out  high in SEED, RUN, FLUSH and CMP
//   done       out  high in DONE
//   pass       out  registered signature match, valid while done is high
//   signature  out  [7:0] current MISR contents
// ---------------------------------------------------------------------------
module mult_bist_ctrl #(
  parameter int unsigned PATTERNS  = 255,
  parameter logic [7:0]  LFSR_SEED = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] golden_sig,
  input  logic [7:0] mul_p,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  output logic       test_mode,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    CMP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Count value on which the last pattern is applied.
  localparam logic [7:0] LAST_CNT = 8'(PATTERNS - 1);

  state_t     state;
  logic [7:0] lfsr;
  logic [7:0] misr;
  logic [7:0] cnt;

  // Next LFSR value and MISR shift term; feedback taps at bits 7,5,4,3.
  logic [7:0] lfsr_adv;
  logic [7:0] misr_shift;

  assign lfsr_adv   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign misr_shift = {misr[6:0], misr[7] ^ misr[5] ^ misr[4] ^ misr[3]};

`ifdef MULT_BIST_PIPE_EN
  // Registered product and its valid flag. v_q marks p_q as holding a
  // product that was presented during RUN, so the first RUN cycle (nothing
  // captured yet) and the FLUSH cycle (last product still pending) both
  // fall out of the same rule.
  logic [7:0] p_q;
  logic       v_q;
`endif

  // Operands come straight from the LFSR register, so they change only on
  // clock edges.
  assign mul_a     = lfsr[7:4];
  assign mul_b     = lfsr[3:0];
  assign signature = misr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      misr      <= 8'h00;
      cnt       <= 8'h00;
      pass      <= 1'b0;
      test_mode <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MULT_BIST_PIPE_EN
      p_q       <= 8'h00;
      v_q       <= 1'b0;
`endif
    end else begin
`ifdef MULT_BIST_PIPE_EN
      p_q <= mul_p;
      v_q <= (state == RUN);
`endif
      case (state)
        IDLE, DONE: begin
          // done and pass drop as soon as a new run is accepted, so the
          // SEED cycle never shows a stale result.
          if (start) begin
            state     <= SEED;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            test_mode <= 1'b0;
          end
        end

        SEED: begin
          lfsr      <= LFSR_SEED;
          misr      <= 8'h00;
          cnt       <= 8'h00;
          pass      <= 1'b0;
          state     <= RUN;
          test_mode <= 1'b1;
          busy      <= 1'b1;
        end

        RUN: begin
          lfsr <= lfsr_adv;
          cnt  <= cnt + 8'd1;
`ifdef MULT_BIST_PIPE_EN
          if (v_q) begin
            misr <= misr_shift ^ p_q;
          end
          if (cnt == LAST_CNT) begin
            state <= FLUSH;
          end
`else
          misr <= misr_shift ^ mul_p;
          if (cnt == LAST_CNT) begin
            state     <= CMP;
            test_mode <= 1'b0;
          end
`endif
        end

        FLUSH: begin
`ifdef MULT_BIST_PIPE_EN
          if (v_q) begin
            misr <= misr_shift ^ p_q;
          end
`endif
          state     <= CMP;
          test_mode <= 1'b0;
        end

        CMP: begin
          pass      <= (misr == golden_sig);
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          test_mode <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          test_mode <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          pass      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_bist_ctrl
//
// Three controller instances (PATTERNS = 1, 2, 255; seed 8'hFF), each with
// its own behavioural multiplier and a stuck-at-0 fault on product bit 0.
// A table of runs is applied first, followed by hand-written sequences for
// mid-run reset and a randomized set of runs checked against a reference
// signature computed from the LFSR/MISR rules.
// ---------------------------------------------------------------------------
module tb_mult_bist_ctrl;

`ifdef MULT_BIST_PIPE_EN
  localparam int PIPE_LAT = 1;
`else
  localparam int PIPE_LAT = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start_s   [3];
  logic [7:0] golden_s  [3];
  logic [7:0] mul_p_s   [3];
  logic [3:0] mul_a_s   [3];
  logic [3:0] mul_b_s   [3];
  logic       tm_s      [3];
  logic       busy_s    [3];
  logic       done_s    [3];
  logic       pass_s    [3];
  logic [7:0] sig_s     [3];
  logic       fault_s   [3];

  int checks;
  int errors;
  int seen [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int unsigned P = (gi == 0) ? 1 : ((gi == 1) ? 2 : 255);
      // Combinational 4x4 multiplier with optional stuck-at-0 on bit 0.
      assign mul_p_s[gi] = ({4'd0, mul_a_s[gi]} * {4'd0, mul_b_s[gi]})
                           & (fault_s[gi] ? 8'hFE : 8'hFF);
      mult_bist_ctrl #(.PATTERNS(P), .LFSR_SEED(8'hFF)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s[gi]),
        .golden_sig(golden_s[gi]),
        .mul_p     (mul_p_s[gi]),
        .mul_a     (mul_a_s[gi]),
        .mul_b     (mul_b_s[gi]),
        .test_mode (tm_s[gi]),
        .busy      (busy_s[gi]),
        .done      (done_s[gi]),
        .pass      (pass_s[gi]),
        .signature (sig_s[gi])
      );
    end
  endgenerate

  function automatic int pats_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 255);
  endfunction

  // Reference signature: walk the pattern sequence, multiply, compact.
  function automatic logic [7:0] sig_model(input int pats, input bit flt);
    logic [7:0] l;
    logic [7:0] m;
    logic [7:0] p;
    l = 8'hFF;
    m = 8'h00;
    for (int i = 0; i < pats; i++) begin
      p = 8'(int'(l[7:4]) * int'(l[3:0]));
      if (flt) p[0] = 1'b0;
      m = {m[6:0], ^(m & 8'hB8)} ^ p;
      l = {l[6:0], ^(l & 8'hB8)};
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_test_mode"}, 32'(tm_s[k]), 0);
      chk({tag, "_busy"}, 32'(busy_s[k]), 0);
      chk({tag, "_done"}, 32'(done_s[k]), 0);
      chk({tag, "_pass"}, 32'(pass_s[k]), 0);
      chk({tag, "_signature"}, 32'(sig_s[k]), 0);
      chk({tag, "_mul_a"}, 32'(mul_a_s[k]), 32'hF);
      chk({tag, "_mul_b"}, 32'(mul_b_s[k]), 32'hF);
    end
  endtask

  // One complete run on instance k. Returns the cycle count from the edge
  // that sampled start to the first cycle with done high.
  task automatic do_run(input int k, input logic [7:0] g, input bit flt,
                        input bit extra, input bit rec,
                        output int lat, output logic [7:0] sig, output logic p);
    int pats;
    pats = pats_of(k);
    @(negedge clk);
    golden_s[k] = g;
    fault_s[k]  = flt;
    start_s[k]  = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    lat = 1;
    // SEED cycle: previous result already cleared.
    chk("seed_busy", 32'(busy_s[k]), 1);
    chk("seed_done", 32'(done_s[k]), 0);
    chk("seed_pass", 32'(pass_s[k]), 0);
    while (done_s[k] !== 1'b1 && lat < 700) begin
      start_s[k] = (extra && (lat == 2 || lat == 4)) ? 1'b1 : 1'b0;
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        chk("run1_mul_a", 32'(mul_a_s[k]), 32'hF);
        chk("run1_mul_b", 32'(mul_b_s[k]), 32'hF);
        chk("run1_test_mode", 32'(tm_s[k]), 1);
      end
      if (rec && lat >= 2 && lat <= pats + 1)
        seen[{mul_a_s[k], mul_b_s[k]}]++;
    end
    start_s[k] = 1'b0;
    chk("done_reached", 32'(done_s[k]), 1);
    chk("done_latency", 32'(lat), 32'(pats + 3 + PIPE_LAT));
    chk("done_busy", 32'(busy_s[k]), 0);
    sig = sig_s[k];
    p   = pass_s[k];
    fault_s[k] = 1'b0;
  endtask

  typedef struct {
    int         k;
    logic [7:0] golden;
    bit         golden_model;  // golden = fault-free reference signature
    bit         fault;
    bit         extra;         // pulse start again during the run
    bit         rec;           // record LFSR states visited
    logic [7:0] exp_sig;
    bit         sig_model;     // expected signature from reference model
    bit         exp_pass;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int         lat;
    logic [7:0] sig;
    logic       p;
    logic [7:0] g;
    logic [7:0] es;
    int         distinct;
    int         repeats;

    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) seen[i] = 0;
    for (int k = 0; k < 3; k++) begin
      start_s[k]  = 1'b0;
      golden_s[k] = 8'h00;
      fault_s[k]  = 1'b0;
    end

    vecs[0] = '{0, 8'hE1, 0, 0, 0, 0, 8'hE1, 0, 1};
    vecs[1] = '{1, 8'h10, 0, 0, 0, 0, 8'h10, 0, 1};
    vecs[2] = '{1, 8'h11, 0, 0, 0, 0, 8'h10, 0, 0};
    vecs[3] = '{2, 8'h00, 1, 0, 0, 1, 8'h00, 1, 1};
    vecs[4] = '{2, 8'h00, 1, 1, 0, 0, 8'h00, 1, 0};
    vecs[5] = '{2, 8'h00, 1, 0, 1, 0, 8'h00, 1, 1};
    vecs[6] = '{0, 8'hE1, 0, 0, 1, 0, 8'hE1, 0, 1};
    vecs[7] = '{1, 8'h10, 0, 1, 0, 0, 8'h10, 1, 0};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("idle");

    for (int i = 0; i < 8; i++) begin
      g  = vecs[i].golden_model ? sig_model(pats_of(vecs[i].k), 1'b0) : vecs[i].golden;
      es = vecs[i].sig_model ? sig_model(pats_of(vecs[i].k), vecs[i].fault) : vecs[i].exp_sig;
      do_run(vecs[i].k, g, vecs[i].fault, vecs[i].extra, vecs[i].rec, lat, sig, p);
      $display("vec %0d: k=%0d golden=%h fault=%0d sig=%h pass=%0d lat=%0d",
               i, vecs[i].k, g, vecs[i].fault, sig, p, lat);
      chk("vec_signature", 32'(sig), 32'(es));
      chk("vec_pass", 32'(p), 32'(vecs[i].exp_pass));
      // Result must hold in DONE.
      repeat (3) @(negedge clk);
      chk("hold_done", 32'(done_s[vecs[i].k]), 1);
      chk("hold_signature", 32'(sig_s[vecs[i].k]), 32'(es));
      chk("hold_pass", 32'(pass_s[vecs[i].k]), 32'(vecs[i].exp_pass));
    end

    // Every non-zero LFSR state exactly once over a 255-pattern run.
    distinct = 0;
    repeats  = 0;
    for (int i = 1; i < 256; i++) begin
      if (seen[i] == 1) distinct++;
      else if (seen[i] > 1) repeats++;
    end
    chk("lfsr_distinct", 32'(distinct), 255);
    chk("lfsr_repeats", 32'(repeats), 0);
    chk("lfsr_zero", 32'(seen[0]), 0);

    // Mid-run reset on the long instance.
    @(negedge clk);
    golden_s[2] = sig_model(255, 1'b0);
    start_s[2]  = 1'b1;
    @(negedge clk);
    start_s[2] = 1'b0;
    repeat (100) @(negedge clk);
    chk("midrun_busy", 32'(busy_s[2]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset("midrun_reset");
    do_run(2, sig_model(255, 1'b0), 1'b0, 1'b0, 1'b0, lat, sig, p);
    $display("rerun after reset: sig=%h pass=%0d lat=%0d", sig, p, lat);
    chk("rerun_signature", 32'(sig), 32'(sig_model(255, 1'b0)));
    chk("rerun_pass", 32'(p), 1);

    // Randomized runs against the reference model.
    for (int r = 0; r < 10; r++) begin
      int k;
      bit flt;
      bit ex;
      k   = $urandom_range(0, 2);
      flt = 1'($urandom_range(0, 1));
      ex  = 1'($urandom_range(0, 1));
      g   = ($urandom_range(0, 1) == 1) ? sig_model(pats_of(k), 1'b0) : 8'($urandom);
      es  = sig_model(pats_of(k), flt);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(k, g, flt, ex, 1'b0, lat, sig, p);
      $display("rand %0d: k=%0d golden=%h fault=%0d sig=%h pass=%0d lat=%0d",
               r, k, g, flt, sig, p, lat);
      chk("rand_signature", 32'(sig), 32'(es));
      chk("rand_pass", 32'(p), 32'(g == es));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
